// File: rtl/span_cme_loader.sv
// span_cme_loader: streams a SPAN parameter frame into span_cme and returns the result.
// Define SPAN_CME_LOADER_POLL_EN to poll the status register instead of a fixed wait.
module span_cme_loader #(
    parameter int         NUM_REGS      = 29,
    parameter logic [4:0] RESULT_OFFSET = 5'd29,
    parameter logic [4:0] STATUS_OFFSET = 5'd30,
    parameter int         WAIT_CYCLES   = 8,
    parameter int         POLL_LIMIT    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic [15:0] writeData,
    output logic [4:0]  offset,
    output logic        write,
    output logic        read,
    output logic        chipselect,
    input  logic [15:0] readData,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_RD,
        S_CAP,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_cnt;
    logic        r_write;
    logic [4:0]  r_offset;
    logic [15:0] r_wdata;
    logic [15:0] r_res;
    logic        r_tout;
    logic        w_accept;
    logic        w_last;
    logic        w_stat_rd;
    logic        w_wait_done;
    logic        w_timeout;
    logic        w_unused_cfg;

    assign in_ready = !reset &&
                      ((r_state == S_IDLE) ||
                       ((r_state == S_LOAD) && (r_cnt < 5'(NUM_REGS))));
    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_cnt == 5'(NUM_REGS - 1));

`ifdef SPAN_CME_LOADER_POLL_EN
    logic       r_ph;
    logic [7:0] r_polls;

    // The first WAIT cycle still carries the final write, so no status read then.
    assign w_stat_rd   = (r_state == S_WAIT) && !r_ph && !r_write;
    assign w_wait_done = (r_state == S_WAIT) && r_ph && readData[0];
    assign w_timeout   = (r_state == S_WAIT) && r_ph && !readData[0] &&
                         (r_polls == 8'(POLL_LIMIT));
    assign w_unused_cfg = (WAIT_CYCLES != 0);

    always_ff @(posedge clk) begin
        if (reset || (r_state != S_WAIT)) begin
            r_ph    <= 1'b0;
            r_polls <= 8'd0;
        end else if (w_stat_rd) begin
            r_ph    <= 1'b1;
            r_polls <= r_polls + 8'd1;
        end else if (r_ph) begin
            r_ph    <= 1'b0;
        end
    end

    assign res_timeout = r_tout;
`else
    logic [7:0] r_wcnt;

    assign w_stat_rd    = 1'b0;
    assign w_wait_done  = (r_state == S_WAIT) && (r_wcnt == 8'(WAIT_CYCLES));
    assign w_timeout    = 1'b0;
    assign w_unused_cfg = (POLL_LIMIT != 0) || r_tout;

    always_ff @(posedge clk) begin
        if (reset || (r_state != S_WAIT)) begin
            r_wcnt <= 8'd0;
        end else begin
            r_wcnt <= r_wcnt + 8'd1;
        end
    end

    assign res_timeout = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_last ? S_WAIT : S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_accept && w_last) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_timeout) begin
                    w_next = S_RESP;
                end else if (w_wait_done) begin
                    w_next = S_RD;
                end
            end
            S_RD:   w_next = S_CAP;
            S_CAP:  w_next = S_RESP;
            S_RESP: begin
                if (res_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 5'd0;
            r_write  <= 1'b0;
            r_offset <= 5'd0;
            r_wdata  <= 16'd0;
            r_res    <= 16'd0;
            r_tout   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_write <= w_accept;
            if (w_accept) begin
                r_offset <= r_cnt;
                r_wdata  <= in_data;
                r_cnt    <= r_cnt + 5'd1;
            end else if ((r_state == S_RESP) && res_ready) begin
                r_cnt    <= 5'd0;
            end
            if (r_state == S_CAP) begin
                r_res  <= readData;
                r_tout <= 1'b0;
            end else if (w_timeout) begin
                r_res  <= 16'd0;
                r_tout <= 1'b1;
            end
        end
    end

    // Reads override the held write offset only for their own cycle.
    assign read       = (r_state == S_RD) || w_stat_rd;
    assign offset     = (r_state == S_RD) ? RESULT_OFFSET :
                        (w_stat_rd ? STATUS_OFFSET : r_offset);
    assign write      = r_write;
    assign writeData  = r_wdata;
    assign chipselect = r_write || read;
    assign res_valid  = (r_state == S_RESP);
    assign res_data   = r_res;

endmodule

// File: tb/tb_span_cme_loader.sv
// Self-checking bench for span_cme_loader: random frames against a bus-level model.
`timescale 1ns/1ps
module tb_span_cme_loader;

    localparam int NUM_REGS = 29;
`ifdef SPAN_CME_LOADER_POLL_EN
    localparam int POLL_LIMIT = 16;
`else
    localparam int WAIT_CYCLES = 8;
`endif

    typedef struct {
        int          cyc;
        logic [4:0]  off;
        logic [15:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'd0;
    logic [15:0] writeData;
    logic [4:0]  offset;
    logic        write;
    logic        read;
    logic        chipselect;
    logic [15:0] readData;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic        res_timeout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stat_total = 0;
    int stat_base = 0;
    int done_at = 1;
    logic [15:0] result_val = 16'd0;
    logic [15:0] frame [NUM_REGS];

    ev_t wlog[$];
    ev_t rlog[$];
    int  acc[$];

    span_cme_loader dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .writeData  (writeData),
        .offset     (offset),
        .write      (write),
        .read       (read),
        .chipselect (chipselect),
        .readData   (readData),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_timeout(res_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register slave model: result at 29, done bit at 30 from the done_at-th poll on.
    always @(posedge clk) begin
        if (reset) begin
            readData <= 16'd0;
        end else if (read && offset == 5'd29) begin
            readData <= result_val;
        end else if (read && offset == 5'd30) begin
            stat_total <= stat_total + 1;
            readData <= {15'd0, (done_at != 0) && (stat_total + 1 - stat_base >= done_at)};
        end else begin
            readData <= 16'hA5A4;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (write) wlog.push_back('{cyc, offset, writeData});
            if (read) rlog.push_back('{cyc, offset, 16'd0});
            if (in_valid && in_ready) acc.push_back(cyc);
        end
    end

    task automatic rand_frame();
        for (int k = 0; k < NUM_REGS; k++) frame[k] = 16'($urandom);
        result_val = 16'($urandom);
    endtask

    task automatic drive_words(input int n, input bit gapped);
        int i = 0;
        int guard = 0;
        bit tog = 1'b0;
        bit a;
        while (i < n && guard < 400) begin
            in_valid = gapped ? tog : 1'b1;
            in_data = frame[i];
            @(negedge clk);
            a = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (a) i++;
            tog = ~tog;
            guard++;
        end
        in_valid = 1'b0;
        checks++;
        if (i != n) begin
            errors++;
            $display("FAIL drive_accepts got=%0d exp=%0d", i, n);
        end
    endtask

    task automatic wait_result(output int rcyc);
        int k = 0;
        @(negedge clk);
        while (!res_valid && k < 400) begin
            @(negedge clk);
            k++;
        end
        rcyc = cyc;
        checks++;
        if (res_valid !== 1'b1) begin
            errors++;
            $display("FAIL result_wait got=%b exp=1", res_valid);
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({in_ready, write, read, chipselect, res_valid, res_timeout,
                 writeData, offset, res_data} !== '0) begin
                errors++;
                $display("FAIL reset_outputs rdy=%b wr=%b rd=%b cs=%b v=%b to=%b wd=%h off=%0d rs=%h exp=all0",
                         in_ready, write, read, chipselect, res_valid, res_timeout,
                         writeData, offset, res_data);
            end
            if (i < 2) @(posedge clk);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1 || write !== 1'b0 || read !== 1'b0 || chipselect !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_reset rdy=%b wr=%b rd=%b cs=%b exp=1,0,0,0",
                         in_ready, write, read, chipselect);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream();
        int wb, rb, ab, rcyc, nres, nstat, rd_cyc;
        rand_frame();
        frame[0] = 16'd300;  frame[1] = 16'd30;    frame[2] = 16'd30;
        frame[3] = 16'hFFF6; frame[4] = 16'hFFF6;  frame[5] = 16'hFFEC;
        frame[6] = 16'd5;    frame[28] = 16'd120;
        result_val = 16'h0055;
        done_at = 1;
        stat_base = stat_total;
        wb = wlog.size(); rb = rlog.size(); ab = acc.size();
        res_ready = 1'b1;
        drive_words(NUM_REGS, 1'b0);
        wait_result(rcyc);
        checks++;
        if (wlog.size() - wb != NUM_REGS) begin
            errors++;
            $display("FAIL stream_write_count got=%0d exp=%0d", wlog.size() - wb, NUM_REGS);
        end
        for (int k = 0; k < NUM_REGS && wb + k < wlog.size(); k++) begin
            checks++;
            if (wlog[wb+k].off !== 5'(k) || wlog[wb+k].data !== frame[k] ||
                wlog[wb+k].cyc != wlog[wb].cyc + k) begin
                errors++;
                $display("FAIL stream_write k=%0d off=%0d data=%h cyc=%0d exp off=%0d data=%h cyc=%0d",
                         k, wlog[wb+k].off, wlog[wb+k].data, wlog[wb+k].cyc,
                         k, frame[k], wlog[wb].cyc + k);
            end
        end
        nres = 0; nstat = 0; rd_cyc = -1;
        for (int j = rb; j < rlog.size(); j++) begin
            if (rlog[j].off == 5'd29) begin nres++; rd_cyc = rlog[j].cyc; end
            else if (rlog[j].off == 5'd30) nstat++;
        end
        checks++;
        if (nres != 1) begin
            errors++;
            $display("FAIL stream_result_reads got=%0d exp=1", nres);
        end
`ifndef SPAN_CME_LOADER_POLL_EN
        checks++;
        if (nstat != 0) begin
            errors++;
            $display("FAIL stream_status_reads got=%0d exp=0", nstat);
        end
        if (wlog.size() - wb == NUM_REGS) begin
            checks++;
            if (rd_cyc != wlog[wb+NUM_REGS-1].cyc + WAIT_CYCLES + 1) begin
                errors++;
                $display("FAIL stream_read_time got=%0d exp=%0d",
                         rd_cyc, wlog[wb+NUM_REGS-1].cyc + WAIT_CYCLES + 1);
            end
        end
        // First accept lands on the edge ending its acc cycle.
        if (acc.size() > ab) begin
            checks++;
            if (rcyc != acc[ab] + 1 + NUM_REGS + WAIT_CYCLES + 2) begin
                errors++;
                $display("FAIL stream_res_latency got=%0d exp=%0d",
                         rcyc, acc[ab] + 1 + NUM_REGS + WAIT_CYCLES + 2);
            end
        end
`else
        checks++;
        if (nstat != 1) begin
            errors++;
            $display("FAIL stream_status_reads got=%0d exp=1", nstat);
        end
`endif
        checks++;
        if (res_data !== 16'h0055 || res_timeout !== 1'b0) begin
            errors++;
            $display("FAIL stream_result got=%h/%b exp=0055/0", res_data, res_timeout);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL one_cycle_handshake v=%b rdy=%b exp=0,1", res_valid, in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_gapped();
        int wb, ab, rcyc;
        rand_frame();
        wb = wlog.size(); ab = acc.size();
        res_ready = 1'b1;
        drive_words(NUM_REGS, 1'b1);
        wait_result(rcyc);
        checks++;
        if (wlog.size() - wb != NUM_REGS || acc.size() - ab != NUM_REGS) begin
            errors++;
            $display("FAIL gapped_counts writes=%0d accepts=%0d exp=%0d",
                     wlog.size() - wb, acc.size() - ab, NUM_REGS);
        end
        for (int k = 0; k < NUM_REGS && wb + k < wlog.size() && ab + k < acc.size(); k++) begin
            checks++;
            if (wlog[wb+k].off !== 5'(k) || wlog[wb+k].data !== frame[k] ||
                wlog[wb+k].cyc != acc[ab+k] + 1) begin
                errors++;
                $display("FAIL gapped_write k=%0d off=%0d data=%h cyc=%0d exp off=%0d data=%h cyc=%0d",
                         k, wlog[wb+k].off, wlog[wb+k].data, wlog[wb+k].cyc,
                         k, frame[k], acc[ab+k] + 1);
            end
        end
        checks++;
        if (res_data !== result_val) begin
            errors++;
            $display("FAIL gapped_result got=%h exp=%h", res_data, result_val);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int wb, rcyc;
        rand_frame();
        res_ready = 1'b0;
        drive_words(NUM_REGS, 1'b0);
        wait_result(rcyc);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (res_valid !== 1'b1 || res_data !== result_val || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_result i=%0d v=%b data=%h rdy=%b exp=1,%h,0",
                         i, res_valid, res_data, in_ready, result_val);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_result v=%b rdy=%b exp=0,1", res_valid, in_ready);
        end
        @(posedge clk);
        #1;
        rand_frame();
        wb = wlog.size();
        res_ready = 1'b1;
        drive_words(NUM_REGS, 1'b0);
        wait_result(rcyc);
        checks++;
        if (wlog.size() - wb != NUM_REGS || wlog[wb].off !== 5'd0 ||
            wlog[wlog.size()-1].off !== 5'(NUM_REGS - 1)) begin
            errors++;
            $display("FAIL next_frame_offsets n=%0d first=%0d last=%0d exp=%0d,0,%0d",
                     wlog.size() - wb, wlog[wb].off, wlog[wlog.size()-1].off,
                     NUM_REGS, NUM_REGS - 1);
        end
        checks++;
        if (res_data !== result_val) begin
            errors++;
            $display("FAIL next_frame_result got=%h exp=%h", res_data, result_val);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        int wb, rcyc;
        rand_frame();
        drive_words(13, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (write !== 1'b1 || offset !== 5'd12 || writeData !== frame[12]) begin
            errors++;
            $display("FAIL pre_reset_write wr=%b off=%0d data=%h exp=1,12,%h",
                     write, offset, writeData, frame[12]);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (write !== 1'b0 || read !== 1'b0 || chipselect !== 1'b0 ||
            res_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset wr=%b rd=%b cs=%b v=%b rdy=%b exp=0,0,0,0,1",
                     write, read, chipselect, res_valid, in_ready);
        end
        @(posedge clk);
        #1;
        rand_frame();
        wb = wlog.size();
        res_ready = 1'b1;
        drive_words(NUM_REGS, 1'b0);
        wait_result(rcyc);
        for (int k = 0; k < NUM_REGS && wb + k < wlog.size(); k++) begin
            checks++;
            if (wlog[wb+k].off !== 5'(k) || wlog[wb+k].data !== frame[k]) begin
                errors++;
                $display("FAIL reset_refill k=%0d off=%0d data=%h exp=%0d,%h",
                         k, wlog[wb+k].off, wlog[wb+k].data, k, frame[k]);
            end
        end
        checks++;
        if (res_data !== result_val) begin
            errors++;
            $display("FAIL reset_refill_result got=%h exp=%h", res_data, result_val);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

`ifdef SPAN_CME_LOADER_POLL_EN
    task automatic test_poll(input int d_at);
        int wb, rb, rcyc, nstat, nres, first_stat, last_stat, rd_cyc;
        rand_frame();
        done_at = d_at;
        stat_base = stat_total;
        wb = wlog.size(); rb = rlog.size();
        res_ready = 1'b1;
        drive_words(NUM_REGS, 1'b0);
        wait_result(rcyc);
        nstat = 0; nres = 0; first_stat = -1; last_stat = -1; rd_cyc = -1;
        for (int j = rb; j < rlog.size(); j++) begin
            if (rlog[j].off == 5'd30) begin
                nstat++;
                if (first_stat < 0) first_stat = rlog[j].cyc;
                last_stat = rlog[j].cyc;
            end else if (rlog[j].off == 5'd29) begin
                nres++;
                rd_cyc = rlog[j].cyc;
            end
        end
        checks++;
        if (nstat != (d_at == 0 ? POLL_LIMIT : d_at)) begin
            errors++;
            $display("FAIL poll_status_reads d=%0d got=%0d exp=%0d",
                     d_at, nstat, (d_at == 0 ? POLL_LIMIT : d_at));
        end
        checks++;
        if (wlog.size() - wb != NUM_REGS || first_stat <= wlog[wlog.size()-1].cyc) begin
            errors++;
            $display("FAIL poll_after_writes writes=%0d first_stat=%0d last_wr=%0d",
                     wlog.size() - wb, first_stat, wlog[wlog.size()-1].cyc);
        end
        if (d_at == 0) begin
            checks++;
            if (nres != 0 || res_timeout !== 1'b1 || res_data !== 16'd0) begin
                errors++;
                $display("FAIL poll_timeout nres=%0d to=%b data=%h exp=0,1,0000",
                         nres, res_timeout, res_data);
            end
        end else begin
            checks++;
            if (nres != 1 || rd_cyc <= last_stat || res_timeout !== 1'b0 ||
                res_data !== result_val) begin
                errors++;
                $display("FAIL poll_done nres=%0d rd=%0d last=%0d to=%b data=%h exp=1,>last,0,%h",
                         nres, rd_cyc, last_stat, res_timeout, res_data, result_val);
            end
        end
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_gapped();
        test_backpressure();
        test_mid_reset();
`ifdef SPAN_CME_LOADER_POLL_EN
        test_poll(3);
        test_poll(0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
